// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the 4-slot mux/demux pair.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_BITS = 2;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } tdm_state_t;

  typedef logic [SLOT_BITS-1:0] slot_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter with clear, load-to-1 and increment. Clear wins over load, and load wins over increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_load1,
  input  logic                 i_clr,
  output logic [SLOT_BITS-1:0] o_slot
);
  slot_t r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= slot_t'(1);
    end else if (i_en) begin
      r_cnt <= r_cnt + slot_t'(1);
    end
  end

  assign o_slot = r_cnt;
endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM receiver: frame lock FSM, shadow buffer for slots 0..2, whole-frame output update.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in,
  input  logic                 frame_start,
  output logic [4*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 locked,
  output logic [SLOT_BITS-1:0] slot,
  output logic                 sync_err
);
  tdm_state_t       r_state;
  tdm_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shadow [0:NUM_SLOTS-2];
  logic [4*WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_sync_err;

  slot_t w_slot;
  slot_t w_sh_idx;
  logic  w_sh_wr;
  logic  w_out_ld;
  logic  w_err;
  logic  w_cnt_en;
  logic  w_cnt_ld1;
  logic  w_cnt_clr;

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cnt_en),
    .i_load1 (w_cnt_ld1),
    .i_clr   (w_cnt_clr),
    .o_slot  (w_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_wr     = 1'b0;
    w_sh_idx    = '0;
    w_out_ld    = 1'b0;
    w_err       = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_ld1   = 1'b0;
    w_cnt_clr   = 1'b0;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_start) begin
            w_sh_wr     = 1'b1;
            w_cnt_ld1   = 1'b1;
            w_state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (frame_start && (w_slot != '0)) begin
            // Re-align on the unexpected frame start and keep lock.
            w_err     = 1'b1;
            w_sh_wr   = 1'b1;
            w_cnt_ld1 = 1'b1;
          end else if (!frame_start && (w_slot == '0)) begin
            w_err       = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = HUNT;
          end else if (w_slot == slot_t'(NUM_SLOTS-1)) begin
            w_out_ld = 1'b1;
            w_cnt_en = 1'b1;
          end else begin
            w_sh_wr  = 1'b1;
            w_sh_idx = w_slot;
            w_cnt_en = 1'b1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS-1; k++) r_shadow[k] <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SLOTS-1; k++) begin
        if (w_sh_wr && (w_sh_idx == slot_t'(k))) r_shadow[k] <= in;
      end
      if (w_out_ld) r_out <= {in, r_shadow[2], r_shadow[1], r_shadow[0]};
      r_out_valid <= w_out_ld;
      r_sync_err  <= w_err;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sync_err  = r_sync_err;
  assign locked    = (r_state == SYNC);
  assign slot      = w_slot;
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench: a 1-bit and a 4-bit receiver share clock and reset.
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_fs = 1'b0;
  logic [0:0]  a_in = '0;
  logic [3:0]  a_out;
  logic        a_ov, a_lock, a_err;
  logic [1:0]  a_slot;

  logic        b_valid = 1'b0, b_fs = 1'b0;
  logic [3:0]  b_in = '0;
  logic [15:0] b_out;
  logic        b_ov, b_lock, b_err;
  logic [1:0]  b_slot;

  int total = 0;
  int bad   = 0;

  tdm_demux4 #(.WIDTH(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in(a_in), .frame_start(a_fs),
    .out(a_out), .out_valid(a_ov), .locked(a_lock), .slot(a_slot), .sync_err(a_err)
  );

  tdm_demux4 #(.WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in(b_in), .frame_start(b_fs),
    .out(b_out), .out_valid(b_ov), .locked(b_lock), .slot(b_slot), .sync_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic v, input logic fs);
    a_valid = 1'b1; a_in = v; a_fs = fs;
    tick();
    a_valid = 1'b0; a_fs = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] v, input logic fs);
    b_valid = 1'b1; b_in = v; b_fs = fs;
    tick();
    b_valid = 1'b0; b_fs = 1'b0;
  endtask

  task automatic chk_b(input string tag, input logic [15:0] o, input logic ov,
                       input logic lk, input logic [1:0] sl, input logic er);
    chk({tag, "_out"},  32'(b_out),  32'(o));
    chk({tag, "_ov"},   32'(b_ov),   32'(ov));
    chk({tag, "_lock"}, 32'(b_lock), 32'(lk));
    chk({tag, "_slot"}, 32'(b_slot), 32'(sl));
    chk({tag, "_err"},  32'(b_err),  32'(er));
  endtask

  initial begin
    // reset held for two edges
    tick(); tick();
    chk("rst_a_out", 32'(a_out), 32'h0);
    chk("rst_a_lock", 32'(a_lock), 32'h0);
    chk("rst_a_slot", 32'(a_slot), 32'h0);
    chk("rst_a_ov", 32'(a_ov), 32'h0);
    chk("rst_a_err", 32'(a_err), 32'h0);
    chk_b("rst_b", 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // HUNT filtering: samples without frame_start are ignored
    send_b(4'h7, 1'b0); chk_b("hunt0", 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    send_b(4'h3, 1'b0); chk_b("hunt1", 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    send_b(4'hF, 1'b0); chk_b("hunt2", 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);

    // 1-bit lock-up with 1,0,1,1
    send_a(1'b1, 1'b1);
    chk("lk_a_lock", 32'(a_lock), 32'h1);
    chk("lk_a_slot", 32'(a_slot), 32'h1);
    send_a(1'b0, 1'b0);
    send_a(1'b1, 1'b0);
    chk("lk_a_slot3", 32'(a_slot), 32'h3);
    chk("lk_a_ov_early", 32'(a_ov), 32'h0);
    send_a(1'b1, 1'b0);
    chk("lk_a_out", 32'(a_out), 32'hD);
    chk("lk_a_ov", 32'(a_ov), 32'h1);
    chk("lk_a_slot0", 32'(a_slot), 32'h0);
    tick();
    chk("lk_a_ov_drop", 32'(a_ov), 32'h0);
    chk("lk_a_hold", 32'(a_out), 32'hD);

    // back-to-back frames with gaps
    send_b(4'hA, 1'b1); chk_b("fa0", 16'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();             chk_b("fa_gap", 16'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    send_b(4'hB, 1'b0);
    send_b(4'hC, 1'b0);
    send_b(4'hD, 1'b0); chk_b("fa3", 16'hDCBA, 1'b1, 1'b1, 2'd0, 1'b0);
    tick();             chk_b("fa_hold", 16'hDCBA, 1'b0, 1'b1, 2'd0, 1'b0);
    send_b(4'h1, 1'b1); tick();
    send_b(4'h2, 1'b0); tick();
    send_b(4'h3, 1'b0); tick();
    chk_b("f1_gap", 16'hDCBA, 1'b0, 1'b1, 2'd3, 1'b0);
    send_b(4'h4, 1'b0); chk_b("f1_3", 16'h4321, 1'b1, 1'b1, 2'd0, 1'b0);
    tick();             chk_b("f1_hold", 16'h4321, 1'b0, 1'b1, 2'd0, 1'b0);

    // early frame_start at slot 2: re-align
    send_b(4'h9, 1'b1);
    send_b(4'hE, 1'b0); chk_b("early_s2", 16'h4321, 1'b0, 1'b1, 2'd2, 1'b0);
    send_b(4'h5, 1'b1); chk_b("early_err", 16'h4321, 1'b0, 1'b1, 2'd1, 1'b1);
    send_b(4'h6, 1'b0); chk_b("early_6", 16'h4321, 1'b0, 1'b1, 2'd2, 1'b0);
    send_b(4'h7, 1'b0);
    send_b(4'h8, 1'b0); chk_b("early_done", 16'h8765, 1'b1, 1'b1, 2'd0, 1'b0);

    // missing frame_start at slot 0
    send_b(4'h3, 1'b0); chk_b("miss_err", 16'h8765, 1'b0, 1'b0, 2'd0, 1'b1);
    tick();             chk_b("miss_after", 16'h8765, 1'b0, 1'b0, 2'd0, 1'b0);

    // reset mid-frame at slot 2
    send_b(4'h1, 1'b1);
    send_b(4'h2, 1'b0); chk_b("mid_s2", 16'h8765, 1'b0, 1'b1, 2'd2, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_b("mid_rst", 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    send_b(4'h3, 1'b0);
    send_b(4'h4, 1'b0); chk_b("mid_hunt", 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    send_b(4'hC, 1'b1);
    send_b(4'h0, 1'b0);
    send_b(4'hF, 1'b0); chk_b("mid_s3", 16'h0, 1'b0, 1'b1, 2'd3, 1'b0);
    send_b(4'h2, 1'b0); chk_b("mid_done", 16'h2F0C, 1'b1, 1'b1, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
